// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared FSM encoding, requester IDs and lock limit for the dmem arbiter
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_P = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    localparam logic REQ_ID_P = 1'b0;
    localparam logic REQ_ID_D = 1'b1;

    localparam int LOCK_MAX_DEFAULT = 16;

endpackage

// File: rtl/arb_lock_timer.sv
// rtl/arb_lock_timer.sv - counts cycles spent in an ownership state and flags forced release
module arb_lock_timer
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic in_own,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(LOCK_MAX);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // IDLE always lasts at least one cycle, so holding zero there clears the count on OWN entry
    always_comb begin
        cnt_d = 8'd0;
        if (in_own) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = in_own && (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter with round-robin and bounded locking
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p_req,
    input  logic        d_req,
    input  logic        p_lock,
    input  logic        d_lock,
    input  logic [31:0] p_addr,
    input  logic [31:0] d_addr,
    input  logic [31:0] p_wdata,
    input  logic [31:0] d_wdata,
    input  logic        p_we,
    input  logic        p_byte,
    input  logic        p_half,
    input  logic        p_sext,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic        d_half,
    input  logic        d_sext,
    output logic        p_ack,
    output logic        d_ack,
    output logic [31:0] p_rdata,
    output logic [31:0] d_rdata,
    output logic [31:0] addr_to_mem,
    output logic [31:0] data_to_mem,
    output logic        write_enable_to_mem,
    output logic        byte_to_mem,
    output logic        half_word_to_mem,
    output logic        sign_extend_to_mem,
    input  logic [31:0] data_from_mem,
    output logic        lock_timeout
);

    arb_state_t  state_q, state_d;
    logic        rr_q, rr_d;
    logic        p_ack_q, p_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] p_rdata_q, p_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        p_elig, d_elig;
    logic        grant_p, grant_d;
    logic        expired;
    logic        owner_release;

    arb_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_lock_timer (
        .clock   (clock),
        .reset   (reset),
        .in_own  (state_q != IDLE),
        .expired (expired)
    );

    always_comb begin
        p_elig  = p_req && !p_ack_q && (state_q != OWN_D);
        d_elig  = d_req && !d_ack_q && (state_q != OWN_P);
        grant_p = 1'b0;
        grant_d = 1'b0;
        // Granting is suppressed during reset so no write can reach memory in that cycle
        if (!reset) begin
            if (p_elig && d_elig) begin
                grant_p = (rr_q == REQ_ID_D);
                grant_d = (rr_q == REQ_ID_P);
            end else begin
                grant_p = p_elig;
                grant_d = d_elig;
            end
        end

        state_d       = state_q;
        owner_release = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_p && p_lock) begin
                    state_d = OWN_P;
                end else if (grant_d && d_lock) begin
                    state_d = OWN_D;
                end
            end
            OWN_P: begin
                owner_release = grant_p && !p_lock;
                if (expired || owner_release) begin
                    state_d = IDLE;
                end
            end
            OWN_D: begin
                owner_release = grant_d && !d_lock;
                if (expired || owner_release) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        lock_timeout = expired && !owner_release && !reset;

        rr_d = grant_p ? REQ_ID_P : (grant_d ? REQ_ID_D : rr_q);

        p_ack_d   = grant_p;
        d_ack_d   = grant_d;
        p_rdata_d = grant_p ? data_from_mem : p_rdata_q;
        d_rdata_d = grant_d ? data_from_mem : d_rdata_q;

        addr_to_mem         = 32'd0;
        data_to_mem         = 32'd0;
        write_enable_to_mem = 1'b0;
        byte_to_mem         = 1'b0;
        half_word_to_mem    = 1'b0;
        sign_extend_to_mem  = 1'b0;
        if (grant_p) begin
            addr_to_mem         = p_addr;
            data_to_mem         = p_wdata;
            write_enable_to_mem = p_we;
            byte_to_mem         = p_byte;
            half_word_to_mem    = p_half;
            sign_extend_to_mem  = p_sext;
        end else if (grant_d) begin
            addr_to_mem         = d_addr;
            data_to_mem         = d_wdata;
            write_enable_to_mem = d_we;
            byte_to_mem         = d_byte;
            half_word_to_mem    = d_half;
            sign_extend_to_mem  = d_sext;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= REQ_ID_D;
            p_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            p_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            p_ack_q   <= p_ack_d;
            d_ack_q   <= d_ack_d;
            p_rdata_q <= p_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // A reset landing on a pending ack must hide it immediately, not one cycle later
    assign p_ack   = p_ack_q && !reset;
    assign d_ack   = d_ack_q && !reset;
    assign p_rdata = reset ? 32'd0 : p_rdata_q;
    assign d_rdata = reset ? 32'd0 : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;

    localparam int LOCK_MAX_A = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_v, lock_v, we_v, byte_v, half_v, sext_v;
    logic [31:0] addr_a  [2];
    logic [31:0] wdata_a [2];

    logic        a_p_ack, a_d_ack, a_we, a_byte, a_half, a_sext, a_timeout;
    logic [31:0] a_p_rdata, a_d_rdata, a_addr, a_data, a_dfm;
    logic        b_p_ack, b_d_ack, b_we, b_byte, b_half, b_sext, b_timeout;
    logic [31:0] b_p_rdata, b_d_rdata, b_addr, b_data, b_dfm;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Transaction-level model: owner (-1 none, 0 P, 1 D), cycles held, last winner, pending acks, read data
    int          m_owner;
    int          m_cnt;
    int          m_last;
    bit          m_ack [2];
    logic [31:0] m_rd  [2];
    int          m_grant;
    bit          m_expired;
    bit [1:0]    busy;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign a_dfm = memval(a_addr);
    assign b_dfm = memval(b_addr);

    always #5 clock = ~clock;

    dmem_arbiter #(.LOCK_MAX(LOCK_MAX_A)) dut_a (
        .clock(clock), .reset(reset),
        .p_req(req_v[0]), .d_req(req_v[1]), .p_lock(lock_v[0]), .d_lock(lock_v[1]),
        .p_addr(addr_a[0]), .d_addr(addr_a[1]), .p_wdata(wdata_a[0]), .d_wdata(wdata_a[1]),
        .p_we(we_v[0]), .p_byte(byte_v[0]), .p_half(half_v[0]), .p_sext(sext_v[0]),
        .d_we(we_v[1]), .d_byte(byte_v[1]), .d_half(half_v[1]), .d_sext(sext_v[1]),
        .p_ack(a_p_ack), .d_ack(a_d_ack), .p_rdata(a_p_rdata), .d_rdata(a_d_rdata),
        .addr_to_mem(a_addr), .data_to_mem(a_data), .write_enable_to_mem(a_we),
        .byte_to_mem(a_byte), .half_word_to_mem(a_half), .sign_extend_to_mem(a_sext),
        .data_from_mem(a_dfm), .lock_timeout(a_timeout)
    );

    dmem_arbiter dut_b (
        .clock(clock), .reset(reset),
        .p_req(req_v[0]), .d_req(req_v[1]), .p_lock(lock_v[0]), .d_lock(lock_v[1]),
        .p_addr(addr_a[0]), .d_addr(addr_a[1]), .p_wdata(wdata_a[0]), .d_wdata(wdata_a[1]),
        .p_we(we_v[0]), .p_byte(byte_v[0]), .p_half(half_v[0]), .p_sext(sext_v[0]),
        .d_we(we_v[1]), .d_byte(byte_v[1]), .d_half(half_v[1]), .d_sext(sext_v[1]),
        .p_ack(b_p_ack), .d_ack(b_d_ack), .p_rdata(b_p_rdata), .d_rdata(b_d_rdata),
        .addr_to_mem(b_addr), .data_to_mem(b_data), .write_enable_to_mem(b_we),
        .byte_to_mem(b_byte), .half_word_to_mem(b_half), .sign_extend_to_mem(b_sext),
        .data_from_mem(b_dfm), .lock_timeout(b_timeout)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_predict();
        bit elig [2];
        m_grant = -1;
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_v[i] && !m_ack[i] && (m_owner < 0 || m_owner == i);
        end
        if (!reset) begin
            if (elig[0] && elig[1]) m_grant = 1 - m_last;
            else if (elig[0])       m_grant = 0;
            else if (elig[1])       m_grant = 1;
        end
        m_expired = (m_owner >= 0) && (m_cnt == LOCK_MAX_A);
    endtask

    task automatic sample();
        logic [71:0] port_exp;
        bit          released;
        bit          to_exp;
        @(negedge clock);
        model_predict();
        port_exp = 72'd0;
        released = 1'b0;
        if (m_grant >= 0) begin
            port_exp = {4'b0, addr_a[m_grant], wdata_a[m_grant], we_v[m_grant],
                        byte_v[m_grant], half_v[m_grant], sext_v[m_grant]};
            released = (m_grant == m_owner) && !lock_v[m_grant];
        end
        to_exp = m_expired && !released && !reset;
        check("port", {4'b0, a_addr, a_data, a_we, a_byte, a_half, a_sext}, port_exp);
        check("ack", 72'({a_p_ack, a_d_ack}), 72'({m_ack[0] && !reset, m_ack[1] && !reset}));
        check("p_rdata", 72'(a_p_rdata), reset ? 72'd0 : 72'(m_rd[0]));
        check("d_rdata", 72'(a_d_rdata), reset ? 72'd0 : 72'(m_rd[1]));
        check("lock_timeout", 72'(a_timeout), 72'(to_exp));
    endtask

    task automatic advance();
        @(posedge clock);
        if (reset) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = 1;
            m_ack   = '{1'b0, 1'b0};
            m_rd    = '{32'd0, 32'd0};
        end else begin
            for (int i = 0; i < 2; i++) m_ack[i] = (m_grant == i);
            if (m_grant >= 0) begin
                m_rd[m_grant] = memval(addr_a[m_grant]);
                m_last        = m_grant;
            end
            if (m_owner < 0) begin
                if (m_grant >= 0 && lock_v[m_grant]) begin
                    m_owner = m_grant;
                    m_cnt   = 0;
                end
            end else if (m_expired || (m_grant == m_owner && !lock_v[m_owner])) begin
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_v = '0; lock_v = '0; we_v = '0; byte_v = '0; half_v = '0; sext_v = '0;
        addr_a = '{32'd0, 32'd0};
        wdata_a = '{32'h1111_0000, 32'h2222_0000};
        m_owner = -1; m_cnt = 0; m_last = 1;
        m_ack = '{1'b0, 1'b0};
        m_rd = '{32'd0, 32'd0};
        busy = '0;
        #1;
        sample(); advance();
        sample(); advance();
        reset = 1'b0;

        sample();
        check("rst_flags", 72'({a_p_ack, a_d_ack, a_timeout}), 72'd0);
        check("rst_rdata", 72'({a_p_rdata, a_d_rdata}), 72'd0);
        advance();

        // Processor read of the word at 0x100
        addr_a[0] = 32'h100; req_v[0] = 1'b1;
        sample();
        check("r31_addr", 72'(a_addr), 72'(32'h100));
        advance();
        req_v[0] = 1'b0;
        sample();
        check("r31_ack", 72'(a_p_ack), 72'd1);
        check("r31_rdata", 72'(a_p_rdata), 72'(32'hDEADBEEF));
        advance();

        // Both requesting continuously: strict alternation starting with P
        reset = 1'b1; sample(); advance(); reset = 1'b0;
        addr_a = '{32'h200, 32'h300}; we_v = 2'b10; lock_v = 2'b00; req_v = 2'b11;
        for (int i = 0; i < 8; i++) begin
            sample();
            check("r32_addr", 72'(a_addr), (i % 2 == 0) ? 72'(32'h200) : 72'(32'h300));
            check("r32_we", 72'(a_we), 72'(i % 2));
            advance();
        end
        req_v = 2'b00;
        sample(); advance();
        sample(); advance();

        // D holds a lock over three writes then releases; P waits (default-limit instance)
        reset = 1'b1; sample(); advance(); reset = 1'b0;
        addr_a = '{32'h240, 32'h340}; we_v = 2'b10; lock_v = 2'b10; req_v = 2'b10;
        for (int i = 0; i < 8; i++) begin
            sample();
            check("r33_addr", 72'(b_addr),
                  (i == 7) ? 72'(32'h240) : ((i % 2 == 0) ? 72'(32'h340) : 72'd0));
            check("r33_timeout", 72'(b_timeout), 72'd0);
            advance();
            if (i == 0) req_v[0] = 1'b1;
            if (i == 5) lock_v[1] = 1'b0;
        end
        req_v = 2'b00;
        sample(); advance();
        sample(); advance();

        // D locks then goes quiet: forced release after LOCK_MAX_A owned cycles
        reset = 1'b1; sample(); advance(); reset = 1'b0;
        addr_a = '{32'h280, 32'h380}; we_v = 2'b00; lock_v = 2'b10; req_v = 2'b10;
        sample();
        check("r34_grant_d", 72'(a_addr), 72'(32'h380));
        advance();
        req_v = 2'b01; lock_v = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            sample();
            check("r34_timeout", 72'(a_timeout), 72'(i == 5));
            check("r34_addr", 72'(a_addr), (i == 6) ? 72'(32'h280) : 72'd0);
            advance();
        end
        req_v = 2'b00;
        sample(); advance();

        // Reset in the cycle after a locked D write grant
        reset = 1'b1; sample(); advance(); reset = 1'b0;
        addr_a = '{32'h2C0, 32'h3C0}; we_v = 2'b10; lock_v = 2'b10; req_v = 2'b10;
        sample();
        check("r35_grant", 72'(a_addr), 72'(32'h3C0));
        advance();
        reset = 1'b1;
        sample();
        check("r35_ack", 72'({a_p_ack, a_d_ack}), 72'd0);
        check("r35_rdata", 72'(a_d_rdata), 72'd0);
        check("r35_port", {4'b0, a_addr, a_data, a_we, a_byte, a_half, a_sext}, 72'd0);
        advance();
        reset = 1'b0; req_v = 2'b01; lock_v = 2'b00; we_v = 2'b00;
        sample();
        check("r35_idle", 72'(a_addr), 72'(32'h2C0));
        check("r35_noack", 72'({a_d_ack, a_d_rdata}), 72'd0);
        advance();
        req_v = 2'b00;
        sample(); advance();

        // Randomized traffic with occasional locks and resets
        busy = '0;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!busy[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        busy[i]    = 1'b1;
                        req_v[i]   = 1'b1;
                        addr_a[i]  = ($urandom_range(0, 7) == 0) ? 32'h100
                                                                 : {20'd0, 10'($urandom), 2'b00};
                        wdata_a[i] = $urandom;
                        lock_v[i]  = ($urandom_range(0, 3) == 0);
                        we_v[i]    = 1'($urandom);
                        byte_v[i]  = 1'($urandom);
                        half_v[i]  = 1'($urandom);
                        sext_v[i]  = 1'($urandom);
                    end else begin
                        req_v[i] = 1'b0;
                    end
                end
            end
            sample();
            advance();
            for (int i = 0; i < 2; i++) begin
                if (reset || m_ack[i]) busy[i] = 1'b0;
            end
        end
        reset = 1'b0;
        req_v = 2'b00;
        sample(); advance();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
